// File: rtl/combat_arbiter.sv
// Per-frame hit arbitration between two fighters: owns hit-stun timers,
// single-connect flags and saturating damage accumulators for both players.
module combat_arbiter #(
    parameter int unsigned STUN_FRAMES = 20,
    parameter int unsigned DAMAGE_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                round_reset,
    input  logic                p1_attack_active,
    input  logic                p2_attack_active,
    input  logic [3:0]          p1_anim_state,
    input  logic [3:0]          p2_anim_state,
    input  logic                p1_hits_p2,
    input  logic                p2_hits_p1,
    output logic                p1_hit_stun_active,
    output logic                p2_hit_stun_active,
    output logic [DAMAGE_W-1:0] p1_damage,
    output logic [DAMAGE_W-1:0] p2_damage,
    output logic                p1_hit_pulse,
    output logic                p2_hit_pulse
);

    typedef enum logic {READY, STUNNED} stun_state_e;

    stun_state_e         state1_q, state1_d, state2_q, state2_d;
    logic [7:0]          stun1_q, stun1_d, stun2_q, stun2_d;
    logic                conn1_q, conn1_d, conn2_q, conn2_d;
    logic [DAMAGE_W-1:0] dmg1_q, dmg1_d, dmg2_q, dmg2_d;
    logic                pulse1_q, pulse1_d, pulse2_q, pulse2_d;
    logic [2:0]          lk1, lk2;
    logic                hit12, hit21;

    function automatic logic [2:0] hit_damage(input logic [3:0] anim);
        case (anim)
            4'd6:    return 3'd3;
            4'd7:    return 3'd5;
            4'd8:    return 3'd4;
            4'd9:    return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

    // Add one step wider than the accumulator so the carry reveals overflow.
    function automatic logic [DAMAGE_W-1:0] sat_add(input logic [DAMAGE_W-1:0] acc,
                                                     input logic [2:0] inc);
        logic [DAMAGE_W:0] sum;
        sum = {1'b0, acc} + {{(DAMAGE_W-2){1'b0}}, inc};
        return sum[DAMAGE_W] ? '1 : sum[DAMAGE_W-1:0];
    endfunction

    assign lk1 = hit_damage(p1_anim_state);
    assign lk2 = hit_damage(p2_anim_state);

    // Both decisions use pre-tick state only, so simultaneous hits trade.
    assign hit12 = frame_tick && p1_attack_active && p1_hits_p2 && !conn1_q &&
                   (state1_q == READY) && (state2_q == READY) && (lk1 != 3'd0);
    assign hit21 = frame_tick && p2_attack_active && p2_hits_p1 && !conn2_q &&
                   (state2_q == READY) && (state1_q == READY) && (lk2 != 3'd0);

    always_comb begin
        stun1_d  = stun1_q;
        stun2_d  = stun2_q;
        conn1_d  = conn1_q;
        conn2_d  = conn2_q;
        dmg1_d   = dmg1_q;
        dmg2_d   = dmg2_q;
        pulse1_d = 1'b0;
        pulse2_d = 1'b0;

        if (frame_tick) begin
            if (hit12) begin
                stun2_d  = 8'(STUN_FRAMES);
                dmg2_d   = sat_add(dmg2_q, lk1);
                pulse2_d = 1'b1;
            end else if (stun2_q != 8'd0) begin
                stun2_d = stun2_q - 8'd1;
            end

            if (hit21) begin
                stun1_d  = 8'(STUN_FRAMES);
                dmg1_d   = sat_add(dmg1_q, lk2);
                pulse1_d = 1'b1;
            end else if (stun1_q != 8'd0) begin
                stun1_d = stun1_q - 8'd1;
            end

            conn1_d = p1_attack_active && (conn1_q || hit12);
            conn2_d = p2_attack_active && (conn2_q || hit21);
        end

        state1_d = (stun1_d != 8'd0) ? STUNNED : READY;
        state2_d = (stun2_d != 8'd0) ? STUNNED : READY;
    end

    always_ff @(posedge clk) begin
        if (reset || round_reset) begin
            state1_q <= READY;
            state2_q <= READY;
            stun1_q  <= '0;
            stun2_q  <= '0;
            conn1_q  <= 1'b0;
            conn2_q  <= 1'b0;
            dmg1_q   <= '0;
            dmg2_q   <= '0;
            pulse1_q <= 1'b0;
            pulse2_q <= 1'b0;
        end else begin
            state1_q <= state1_d;
            state2_q <= state2_d;
            stun1_q  <= stun1_d;
            stun2_q  <= stun2_d;
            conn1_q  <= conn1_d;
            conn2_q  <= conn2_d;
            dmg1_q   <= dmg1_d;
            dmg2_q   <= dmg2_d;
            pulse1_q <= pulse1_d;
            pulse2_q <= pulse2_d;
        end
    end

    assign p1_hit_stun_active = (state1_q == STUNNED);
    assign p2_hit_stun_active = (state2_q == STUNNED);
    assign p1_damage          = dmg1_q;
    assign p2_damage          = dmg2_q;
    assign p1_hit_pulse       = pulse1_q;
    assign p2_hit_pulse       = pulse2_q;

endmodule

// File: tb/tb_combat_arbiter.sv
// Bench for combat_arbiter: directed scenarios plus random frames, checked
// against a per-player integer model; a 3-bit-damage instance covers saturation.
module tb_combat_arbiter;

    localparam int STUN = 20;

    logic clk = 1'b0;
    logic reset, frame_tick, round_reset;
    logic a1, a2, h12, h21;
    logic [3:0] an1, an2;

    logic       s1, s2, pl1, pl2, s1n, s2n, pl1n, pl2n;
    logic [7:0] d1, d2;
    logic [2:0] d1n, d2n;

    int checks = 0;
    int errors = 0;

    int stun_m[2], conn_m[2], dmg_m[2], dmg3_m[2], pulse_m[2];
    int dmg_tab[16];

    always #5 clk = ~clk;

    combat_arbiter #(.STUN_FRAMES(STUN), .DAMAGE_W(8)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .round_reset(round_reset),
        .p1_attack_active(a1), .p2_attack_active(a2),
        .p1_anim_state(an1), .p2_anim_state(an2),
        .p1_hits_p2(h12), .p2_hits_p1(h21),
        .p1_hit_stun_active(s1), .p2_hit_stun_active(s2),
        .p1_damage(d1), .p2_damage(d2),
        .p1_hit_pulse(pl1), .p2_hit_pulse(pl2)
    );

    combat_arbiter #(.STUN_FRAMES(STUN), .DAMAGE_W(3)) dut_narrow (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .round_reset(round_reset),
        .p1_attack_active(a1), .p2_attack_active(a2),
        .p1_anim_state(an1), .p2_anim_state(an2),
        .p1_hits_p2(h12), .p2_hits_p1(h21),
        .p1_hit_stun_active(s1n), .p2_hit_stun_active(s2n),
        .p1_damage(d1n), .p2_damage(d2n),
        .p1_hit_pulse(pl1n), .p2_hit_pulse(pl2n)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step(input bit t);
        int  act[2], ov[2], anim[2];
        bit  hit[2];
        if (reset || round_reset) begin
            for (int p = 0; p < 2; p++) begin
                stun_m[p] = 0; conn_m[p] = 0; dmg_m[p] = 0; dmg3_m[p] = 0; pulse_m[p] = 0;
            end
            return;
        end
        if (!t) begin
            pulse_m[0] = 0; pulse_m[1] = 0;
            return;
        end
        act[0] = a1; act[1] = a2; ov[0] = h12; ov[1] = h21; anim[0] = an1; anim[1] = an2;
        for (int p = 0; p < 2; p++)
            hit[p] = act[p] != 0 && ov[p] != 0 && conn_m[p] == 0 && stun_m[p] == 0 &&
                     stun_m[1-p] == 0 && dmg_tab[anim[p]] != 0;
        for (int p = 0; p < 2; p++) begin
            int v = 1 - p;
            if (hit[p]) begin
                stun_m[v]  = STUN;
                dmg_m[v]   = min_i(dmg_m[v] + dmg_tab[anim[p]], 255);
                dmg3_m[v]  = min_i(dmg3_m[v] + dmg_tab[anim[p]], 7);
                pulse_m[v] = 1;
            end else begin
                pulse_m[v] = 0;
                if (stun_m[v] > 0) stun_m[v]--;
            end
        end
        for (int p = 0; p < 2; p++)
            conn_m[p] = (act[p] != 0) ? int'(conn_m[p] != 0 || hit[p]) : 0;
    endtask

    task automatic check_all();
        check("p1_stun",  int'(s1),  int'(stun_m[0] != 0));
        check("p2_stun",  int'(s2),  int'(stun_m[1] != 0));
        check("p1_dmg",   int'(d1),  dmg_m[0]);
        check("p2_dmg",   int'(d2),  dmg_m[1]);
        check("p1_pulse", int'(pl1), pulse_m[0]);
        check("p2_pulse", int'(pl2), pulse_m[1]);
        check("p1_dmg_w3", int'(d1n), dmg3_m[0]);
        check("p2_dmg_w3", int'(d2n), dmg3_m[1]);
    endtask

    task automatic cycle(input bit t);
        frame_tick = t;
        @(posedge clk);
        model_step(t);
        #1;
        check_all();
    endtask

    task automatic tick_gap();
        cycle(1'b1);
        cycle(1'b0);
    endtask

    task automatic clear_round();
        a1 = 0; a2 = 0; h12 = 0; h21 = 0; an1 = 0; an2 = 0;
        round_reset = 1;
        cycle(1'b0);
        round_reset = 0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) dmg_tab[i] = 0;
        dmg_tab[6] = 3; dmg_tab[7] = 5; dmg_tab[8] = 4; dmg_tab[9] = 6;
        for (int p = 0; p < 2; p++) begin
            stun_m[p] = 0; conn_m[p] = 0; dmg_m[p] = 0; dmg3_m[p] = 0; pulse_m[p] = 0;
        end
        reset = 1; round_reset = 0; frame_tick = 0;
        a1 = 0; a2 = 0; h12 = 0; h21 = 0; an1 = 0; an2 = 0;
        cycle(1'b0);
        cycle(1'b0);
        reset = 0;
        check("reset_p2_dmg", int'(d2), 0);

        // Single side hit, then exact stun length
        a1 = 1; an1 = 7; h12 = 1;
        cycle(1'b1);
        a1 = 0; h12 = 0;
        check("hit_p2_stun", int'(s2), 1);
        check("hit_p2_dmg", int'(d2), 5);
        check("hit_p2_pulse", int'(pl2), 1);
        cycle(1'b0);
        check("pulse_drop", int'(pl2), 0);
        for (int i = 0; i < STUN - 1; i++) tick_gap();
        check("stun_before_last", int'(s2), 1);
        cycle(1'b1);
        check("stun_after_last", int'(s2), 0);

        // Sustained overlap connects once; fresh attack after stun connects again
        clear_round();
        a1 = 1; an1 = 6; h12 = 1;
        for (int i = 0; i < 10; i++) tick_gap();
        check("sustained_dmg", int'(d2), 3);
        a1 = 0;
        for (int i = 0; i < 12; i++) tick_gap();
        a1 = 1;
        tick_gap();
        check("reconnect_dmg", int'(d2), 6);

        // Trade
        clear_round();
        a1 = 1; an1 = 9; h12 = 1; a2 = 1; an2 = 8; h21 = 1;
        cycle(1'b1);
        check("trade_p1_dmg", int'(d1), 4);
        check("trade_p2_dmg", int'(d2), 6);
        check("trade_both_stun", int'(s1 && s2), 1);

        // Invulnerability during stun
        clear_round();
        a1 = 1; an1 = 7; h12 = 1;
        tick_gap();
        a1 = 0; tick_gap();
        a1 = 1; tick_gap();
        check("invuln_dmg", int'(d2), 5);
        a1 = 0;
        for (int i = 0; i < STUN; i++) tick_gap();
        a1 = 1;
        cycle(1'b1);
        check("post_stun_dmg", int'(d2), 10);
        check("post_stun_pulse", int'(pl2), 1);

        // Saturation on the narrow instance: 5, 7, 7
        clear_round();
        for (int k = 0; k < 3; k++) begin
            a1 = 1; an1 = 7; h12 = 1;
            tick_gap();
            a1 = 0;
            for (int i = 0; i < STUN + 1; i++) tick_gap();
        end
        check("sat_w3_dmg", int'(d2n), 7);

        // round_reset mid-stun on a non-tick cycle, then anim 0 never hits
        clear_round();
        a1 = 1; an1 = 7; h12 = 1;
        tick_gap();
        round_reset = 1;
        cycle(1'b0);
        round_reset = 0;
        check("rr_stun", int'(s2), 0);
        check("rr_dmg", int'(d2), 0);
        a1 = 0; tick_gap();
        a1 = 1; an1 = 0; h12 = 1;
        tick_gap();
        check("anim0_nohit", int'(d2), 0);

        // Random frames
        clear_round();
        for (int i = 0; i < 4000; i++) begin
            a1  = ($urandom_range(0, 3) != 0);
            a2  = ($urandom_range(0, 3) != 0);
            h12 = 1'($urandom_range(0, 1));
            h21 = 1'($urandom_range(0, 1));
            an1 = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(6, 9));
            an2 = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(6, 9));
            round_reset = ($urandom_range(0, 399) == 0);
            cycle($urandom_range(0, 2) != 0);
        end
        round_reset = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
